// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings and helpers for the load/store sequencer
package mem_access_unit_pkg;

  // Native data width of the SRAM datapath; the lane logic is written for 8 lanes.
  localparam int MAU_DATA_W = 64;
  localparam int MAU_LANES  = MAU_DATA_W / 8;

  // Access size encodings as carried on req_size.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // An access is misaligned when any address bit below its natural alignment is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane mask, store replication and load extract/extend
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [2:0]            offset,
  input  logic [MAU_DATA_W-1:0] wdata,
  input  logic [MAU_DATA_W-1:0] rdata,
  output logic [MAU_LANES-1:0]  mask,
  output logic [MAU_DATA_W-1:0] wdata_rep,
  output logic [MAU_DATA_W-1:0] rdata_ext
);

  logic [MAU_DATA_W-1:0] shifted;

  // Move the addressed lane down to bit 0, then size, replicate and extend per access width.
  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    mask      = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      SZ_B: begin
        mask      = 8'h01 << offset;
        wdata_rep = {8{wdata[7:0]}};
        rdata_ext = is_unsigned ? {56'd0, shifted[7:0]}
                                : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        mask      = 8'h03 << offset;
        wdata_rep = {4{wdata[15:0]}};
        rdata_ext = is_unsigned ? {48'd0, shifted[15:0]}
                                : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        mask      = 8'h0F << offset;
        wdata_rep = {2{wdata[31:0]}};
        rdata_ext = is_unsigned ? {32'd0, shifted[31:0]}
                                : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        // Doubles fill the whole word, so extension does not apply.
        mask      = 8'hFF << offset;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store sequencer in front of the data SRAM
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The lane logic only knows an 8-lane datapath; refuse to build anything else.
  if (DATA_W != MAU_DATA_W) begin : g_bad_width
    $error("mem_access_unit: only DATA_W=64 is supported");
  end

  state_e      state;
  state_e      state_nxt;

  logic        lat_wen;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [2:0]  lat_offset;
  logic [7:0]  lat_mask;

  logic        accept;
  logic        req_mis;

  logic [1:0]  al_size;
  logic        al_unsigned;
  logic [2:0]  al_offset;
  logic [7:0]  al_mask;
  logic [DATA_W-1:0] al_wrep;
  logic [DATA_W-1:0] al_rext;

  assign accept  = (state == ST_IDLE) && req_valid;
  assign req_mis = is_misaligned(req_size, req_addr[2:0]);

  // One lane aligner serves both phases: the live request while idle (mask and
  // replication are captured at accept) and the latched request afterwards (load extract).
  assign al_size     = (state == ST_IDLE) ? req_size     : lat_size;
  assign al_unsigned = (state == ST_IDLE) ? req_unsigned : lat_unsigned;
  assign al_offset   = (state == ST_IDLE) ? req_addr[2:0] : lat_offset;

  mem_lane_align u_align (
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .offset      (al_offset),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .mask        (al_mask),
    .wdata_rep   (al_wrep),
    .rdata_ext   (al_rext)
  );

  // State register; reset drops any in-flight access or pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the state-decoded handshake/SRAM strobes; strobes exist only in ACCESS
  // so an asynchronous reset kills them immediately.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 8'h00;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_mis ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_wen ? lat_mask : 8'h00;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, SRAM address/data staging and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wen       <= 1'b0;
      lat_size      <= 2'd0;
      lat_unsigned  <= 1'b0;
      lat_offset    <= 3'd0;
      lat_mask      <= 8'h00;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else if (accept) begin
      lat_wen       <= req_wen;
      lat_size      <= req_size;
      lat_unsigned  <= req_unsigned;
      lat_offset    <= req_addr[2:0];
      resp_rdata    <= '0;
      resp_misalign <= req_mis;
      // Misaligned requests never reach the SRAM, so its address/data stay as they were.
      if (!req_mis) begin
        lat_mask  <= al_mask;
        mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
        mem_wdata <= al_wrep;
      end
    end else if (state == ST_WAIT) begin
      // SRAM read data is valid in the cycle after the request.
      resp_rdata <= lat_wen ? '0 : al_rext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench with a byte-array memory model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'd0;

  int total = 0;
  int bad   = 0;

  // Reference memory: 64 bytes at 0x80000000, plain byte array.
  logic [7:0]  ref_mem [64];
  // SRAM stand-in: 8 words with registered read data.
  logic [63:0] sram [8];

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM behaviour: byte-enabled write, or read returned on the next cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 8'h00) begin
        mem_rdata <= sram[mem_addr[5:3]];
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (mem_we[b]) sram[mem_addr[5:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, follow it to its response and compare against the byte model.
  task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                         output logic [7:0] got_we, output logic [63:0] got_wd,
                         output logic [63:0] got_rd);
    int          n;
    logic        mis;
    logic [15:0] wide_mask;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
    int          en_cnt;
    int          en_cyc;
    int          rv_cyc;
    int          stray_we;
    int          unstable;
    logic [63:0] seen_addr;
    n         = 1 << size;
    mis       = (addr[5:0] % n) != 0;
    wide_mask = ((16'd1 << n) - 16'd1) << addr[2:0];
    exp_mask  = wide_mask[7:0];
    for (int i = 0; i < 8; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
    exp_rd = 64'd0;
    if (!mis && wen) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr[5:0]) + i] = wdata[8*i +: 8];
    end
    if (!mis && !wen) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[int'(addr[5:0]) + i];
      if (!uns && n < 8 && exp_rd[8*n-1]) begin
        for (int k = 8*n; k < 64; k++) exp_rd[k] = 1'b1;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    req_addr  = {$urandom, $urandom};

    en_cnt = 0; en_cyc = -1; rv_cyc = -1; stray_we = 0;
    got_we = 8'h00; got_wd = 64'd0; seen_addr = 64'd0;
    for (int c = 1; c <= 8 && rv_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        en_cyc    = c;
        got_we    = mem_we;
        got_wd    = mem_wdata;
        seen_addr = mem_addr;
      end else if (mem_we != 8'h00) begin
        stray_we++;
      end
      if (resp_valid) rv_cyc = c;
    end

    if (mis) begin
      chk("mis_no_en", 64'(en_cnt), 64'd0);
      chk("mis_resp_cyc", 64'(rv_cyc), 64'd1);
    end else begin
      chk("en_count", 64'(en_cnt), 64'd1);
      chk("en_cycle", 64'(en_cyc), 64'd1);
      chk("resp_cycle", 64'(rv_cyc), 64'd3);
      chk("mem_we", {56'd0, got_we}, wen ? {56'd0, exp_mask} : 64'd0);
      chk("mem_addr", seen_addr, {addr[63:3], 3'b000});
      if (wen) chk("mem_wdata", got_wd, exp_wd);
    end
    chk("stray_we", 64'(stray_we), 64'd0);
    chk("resp_misalign", {63'd0, resp_misalign}, {63'd0, mis});
    chk("resp_rdata", resp_rdata, exp_rd);
    got_rd = resp_rdata;

    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_misalign !== mis ||
          req_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 8'h00) unstable++;
    end
    if (hold > 0) chk("resp_hold_stable", 64'(unstable), 64'd0);

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_released", {63'd0, resp_valid}, 64'd0);
  endtask

  logic [7:0]  g_we;
  logic [63:0] g_wd;
  logic [63:0] g_rd;
  int          leak;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {56'd0, mem_we}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    rst_n = 1'b1;

    // Fill the whole window so every later load has defined contents.
    for (int w = 0; w < 8; w++) begin
      run_req(1'b1, 2'd3, 1'b0, 64'h8000_0000 + 64'(8*w), {$urandom, $urandom}, 0, g_we, g_wd, g_rd);
    end

    run_req(1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 0, g_we, g_wd, g_rd);
    chk("sd_we", {56'd0, g_we}, 64'hFF);
    chk("sd_wdata", g_wd, 64'h1122_3344_5566_7788);
    chk("sd_rdata", g_rd, 64'd0);

    run_req(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AB, 0, g_we, g_wd, g_rd);
    chk("sb_we", {56'd0, g_we}, 64'h20);
    chk("sb_wdata", g_wd, 64'hABAB_ABAB_ABAB_ABAB);

    run_req(1'b1, 2'd3, 1'b0, 64'h8000_0000, 64'h8001_0000_0000_0000, 0, g_we, g_wd, g_rd);
    run_req(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'd0, 0, g_we, g_wd, g_rd);
    chk("lh_signed", g_rd, 64'hFFFF_FFFF_FFFF_8001);
    run_req(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'd0, 0, g_we, g_wd, g_rd);
    chk("lhu", g_rd, 64'h0000_0000_0000_8001);

    run_req(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 0, g_we, g_wd, g_rd);
    chk("lw_mis_rdata", g_rd, 64'd0);

    run_req(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 5, g_we, g_wd, g_rd);
    chk("ld_hold", g_rd, 64'h1122_3344_5566_7788);

    // Reset in the middle of the SRAM cycle of a load.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr  = 64'h8000_0010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_en", {63'd0, mem_en}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_en_drop", {63'd0, mem_en}, 64'd0);
    chk("rst_we_drop", {56'd0, mem_we}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    leak = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0) leak++;
    end
    resp_ready = 1'b0;
    chk("rst_no_resp", 64'(leak), 64'd0);
    chk("rst_idle_rdata", resp_rdata, 64'd0);

    for (int t = 0; t < 250; t++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              64'h8000_0000 + 64'($urandom_range(0, 63)), {$urandom, $urandom},
              int'($urandom_range(0, 3)), g_we, g_wd, g_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer sitting directly upstream of the 64-bit single-port data SRAM. It drives the SRAM's en/we/addr/wdata and consumes its rdata, which the SRAM registers one cycle after the request.
- Accepts one load/store per handshake from the execute stage and builds the byte-write mask and lane-replicated write data.
- For loads, extracts and sign/zero-extends the addressed lane, then returns the result to writeback through a valid/ready response.

Parameters:
- ADDR_W, 64, request/SRAM address width.
- DATA_W, 64, data width. Only 64 is supported; any other value is a generation error.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_wen  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_misalign  out  1  access was misaligned and not performed
- mem_en  out  1  SRAM enable
- mem_we  out  8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM byte address, 8-byte aligned
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM registered read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0 except req_ready=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch wen, size, unsigned, addr, wdata. If the access is misaligned, go to RESP; otherwise go to ACCESS.
  - ACCESS: one cycle. mem_en=1, mem_addr={addr[ADDR_W-1:3],3'b0}.
    - Stores: mem_we=mask, mem_wdata=replicated data.
    - Loads: mem_we=0.
    - Always goes to WAIT.
  - WAIT: mem_en=0, mem_we=0. mem_rdata is valid this cycle.
    - Loads: at the clock edge, register the extracted value into resp_rdata.
    - Stores: resp_rdata<=0.
    - Always goes to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_misalign are held stable until resp_ready=1, then go to IDLE.
- req_ready is 1 only in IDLE. There is no overlap of requests.
- Back-to-back rate: one access per 4 cycles when resp_ready is tied high.
- Latency: accept at edge T, mem_en high in cycle T+1, resp_valid high in cycle T+3.
- Misaligned access: addr[size-1:0]!=0 (size>0).
  - No SRAM cycle is issued. mem_en stays 0 and mem_we is never asserted.
  - Response arrives the cycle after accept, with resp_misalign=1 and resp_rdata=0.
- Byte mask: mask = ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits.
- Write data replication:
  - byte: {8{wdata[7:0]}}
  - half: {4{wdata[15:0]}}
  - word: {2{wdata[31:0]}}
  - double: wdata
- Load extract: shift mem_rdata right by addr[2:0]*8, take the low (8<<size) bits, then sign- or zero-extend per unsigned. Size 3 ignores unsigned.
- mem_en and mem_we are zero in every state except ACCESS. mem_addr and mem_wdata are don't-care outside ACCESS but are held at their last value.
- resp_ready while resp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; the upstream stage holds its request.
- Reset mid-operation:
  - Reset asserted during ACCESS deasserts mem_en/mem_we immediately (asynchronous).
  - Any in-flight request and any undelivered response are dropped. No response is produced after reset.

Decomposition:
- Shared defines: size encodings (SZ_B/SZ_H/SZ_W/SZ_D), state encodings, and the data width.
- One sub-module, mem_lane_align: combinational mask generation, write replication and load extract/extend, keyed on size/unsigned/addr[2:0]. The top holds the FSM and registers.

Test Plan:
- Store double, addr=0x80000008, wdata=0x1122334455667788 -> in cycle T+1: mem_en=1, mem_we=0xFF, mem_addr=0x80000008, mem_wdata=0x1122334455667788; resp_valid at T+3 with resp_rdata=0, resp_misalign=0.
- Store byte, addr=0x80000005, wdata=0xAB -> mem_we=0x20, mem_wdata=0xABABABABABABABAB.
- Load half signed, addr=0x80000006, mem_rdata=0x8001000000000000 -> resp_rdata=0xFFFFFFFFFFFF8001.
- Same load with unsigned=1 -> resp_rdata=0x8001.
- Load word, addr=0x80000002 -> misaligned: mem_en never 1; resp_valid the cycle after accept with resp_misalign=1, resp_rdata=0.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0. Then assert rst_n=0 mid-ACCESS of the following request -> mem_en drops immediately, and after release state=IDLE, req_ready=1, resp_valid=0.
